// File: rtl/led_bar_pkg.sv
// Shared types and helpers for the LED-bar countdown timer.
package led_bar_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: pulses tick for one cycle each time the count wraps.
module tick_prescaler #(
   parameter int PRESCALE = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   // A divide-by-1 still needs a one-bit register to keep the port widths sane.
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst || clear)
         cnt <= '0;
      else if (run)
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/led_bar_timer.sv
// LED-bar countdown: bar drains one LED per step, flags warning, timeout and expiry.
module led_bar_timer
   import led_bar_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int PRESCALE   = 50_000_000,
   parameter int WARN_LEVEL = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     reconfigure,
   input  logic                     enable,
   input  logic                     step,
   input  logic                     dir,
   output logic [WIDTH-1:0]         led,
   output logic [cnt_w(WIDTH)-1:0]  remaining,
   output logic                     warning,
   output logic                     timeout,
   output logic                     expired
);

   localparam int RW = cnt_w(WIDTH);

   state_t           state, state_n;
   logic             dir_q;
   logic [WIDTH-1:0] led_n;
   logic [RW-1:0]    rem_n;
   logic             timeout_n, expired_n, warning_n;
   logic             tick, step_ev, active;

   assign active = (state != EXPIRED);

   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (reconfigure),
      .run   (enable && active),
      .tick  (tick)
   );

   // Manual and automatic sources merge into a single step.
   assign step_ev = active && (step || tick);

   always_comb begin
      state_n   = state;
      led_n     = led;
      rem_n     = remaining;
      timeout_n = timeout;
      expired_n = 1'b0;

      if (state == IDLE && (enable || step_ev))
         state_n = RUN;

      if (step_ev) begin
         led_n = (dir_q == DIR_RIGHT) ? {1'b0, led[WIDTH-1:1]}
                                      : {led[WIDTH-2:0], 1'b0};
         rem_n = remaining - RW'(1);
         if (remaining == RW'(1)) begin
            state_n   = EXPIRED;
            timeout_n = 1'b1;
            expired_n = 1'b1;
         end
      end

      warning_n = (rem_n != '0) && (int'(rem_n) <= WARN_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (!rst || reconfigure) begin
         state     <= IDLE;
         led       <= '1;
         remaining <= RW'(WIDTH);
         warning   <= 1'b0;
         timeout   <= 1'b0;
         expired   <= 1'b0;
         dir_q     <= dir;
      end else begin
         state     <= state_n;
         led       <= led_n;
         remaining <= rem_n;
         warning   <= warning_n;
         timeout   <= timeout_n;
         expired   <= expired_n;
      end
   end

endmodule

// File: tb/tb_led_bar_timer.sv
// Bench for led_bar_timer: directed scenarios plus random traffic against a count-based model.
module tb_led_bar_timer;

   localparam int W  = 10;
   localparam int P  = 4;
   localparam int WL = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         reconfigure = 1'b0;
   logic         enable = 1'b0;
   logic         step = 1'b0;
   logic         dir = 1'b0;
   logic [W-1:0] led;
   logic [3:0]   remaining;
   logic         warning, timeout, expired;

   int errors = 0;
   int checks = 0;

   // Reference model: LED count, prescaler phase, coarse state (0 idle, 1 run, 2 expired).
   int   m_rem, m_cnt, m_state;
   logic m_dir, m_to, m_exp, m_warn;

   always #5 clk = ~clk;

   led_bar_timer #(.WIDTH(W), .PRESCALE(P), .WARN_LEVEL(WL)) dut (
      .clk         (clk),
      .rst         (rst),
      .reconfigure (reconfigure),
      .enable      (enable),
      .step        (step),
      .dir         (dir),
      .led         (led),
      .remaining   (remaining),
      .warning     (warning),
      .timeout     (timeout),
      .expired     (expired)
   );

   task automatic model_update();
      bit active, fire;
      if (!rst || reconfigure) begin
         m_rem = W; m_cnt = 0; m_state = 0; m_dir = dir;
         m_to = 1'b0; m_exp = 1'b0; m_warn = 1'b0;
      end else begin
         active = (m_state != 2);
         fire   = active && (step || (enable && m_cnt == P - 1));
         m_exp  = 1'b0;
         if (active && enable) m_cnt = (m_cnt + 1) % P;
         if (m_state == 0 && (enable || step)) m_state = 1;
         if (fire) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_state = 2; m_to = 1'b1; m_exp = 1'b1;
            end
         end
         m_warn = (m_rem >= 1 && m_rem <= WL);
      end
   endtask

   // Lit LEDs sit at the low end when draining right, at the high end when draining left.
   function automatic logic [16:0] exp_vec();
      logic [W-1:0] l;
      int full;
      full = (1 << W) - 1;
      l = m_dir ? W'(full & ~((1 << (W - m_rem)) - 1)) : W'((1 << m_rem) - 1);
      return {l, 4'(m_rem), m_warn, m_to, m_exp};
   endfunction

   task automatic clk_cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; dir = 1'b0;
      clk_cycle();
      rst = 1'b1;
      checks++;
      if (led !== 10'h3FF || remaining !== 4'd10 || {warning, timeout, expired} !== 3'b000) begin
         errors++;
         $display("FAIL reset: led=%h rem=%0d w/t/e=%b, want 3ff 10 000", led, remaining, {warning, timeout, expired});
      end
   endtask

   task automatic test_manual_drain();
      logic [W-1:0] full;
      full = 10'h3FF;
      for (int i = 1; i <= W; i++) begin
         step = 1'b1;
         clk_cycle();
         step = 1'b0;
         checks++;
         if (led !== (full >> i) || warning !== ((W - i) >= 1 && (W - i) <= WL)
             || expired !== (i == W) || timeout !== (i == W)) begin
            errors++;
            $display("FAIL drain step %0d: led=%h w=%b t=%b e=%b, want led=%h", i, led, warning, timeout, expired, full >> i);
         end
         clk_cycle();
         checks++;
         if ({led, remaining, warning, timeout, expired} !== exp_vec()) begin
            errors++;
            $display("FAIL drain gap %0d: got %h want %h", i, {led, remaining, warning, timeout, expired}, exp_vec());
         end
      end
      checks++;
      if (expired !== 1'b0 || timeout !== 1'b1) begin
         errors++;
         $display("FAIL expired pulse width: e=%b t=%b, want 0 1", expired, timeout);
      end
   endtask

   task automatic test_prescaler_left();
      dir = 1'b1; reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0; dir = 1'b0; enable = 1'b1;
      for (int i = 1; i <= 44; i++) begin
         clk_cycle();
         checks++;
         if ({led, remaining, warning, timeout, expired} !== exp_vec()) begin
            errors++;
            $display("FAIL left cycle %0d: got %h want %h", i, {led, remaining, warning, timeout, expired}, exp_vec());
         end
         if (i == 3 || i == 4 || i == 8 || i == 39 || i == 40) begin
            checks++;
            if ((i == 3 && led !== 10'h3FF) || (i == 4 && led !== 10'h3FE) || (i == 8 && led !== 10'h3FC)
                || (i == 39 && timeout !== 1'b0) || (i == 40 && {led, timeout, expired} !== 12'h003)) begin
               errors++;
               $display("FAIL left milestone %0d: led=%h t=%b e=%b", i, led, timeout, expired);
            end
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_pause();
      dir = 1'b1; reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0;
      for (int i = 0; i < 10; i++) begin
         enable = (i < 2 || i >= 7);
         clk_cycle();
         checks++;
         if (led !== ((i < 8) ? 10'h3FF : 10'h3FE) || {led, remaining, warning, timeout, expired} !== exp_vec()) begin
            errors++;
            $display("FAIL pause cycle %0d: led=%h rem=%0d", i, led, remaining);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_simultaneous();
      dir = 1'b0; reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0; enable = 1'b1;
      repeat (3) clk_cycle();
      step = 1'b1;
      clk_cycle();
      step = 1'b0; enable = 1'b0;
      checks++;
      if (remaining !== 4'd9 || led !== 10'h1FF) begin
         errors++;
         $display("FAIL step+wrap: rem=%0d led=%h, want 9 1ff", remaining, led);
      end
      step = 1'b1; reconfigure = 1'b1;
      clk_cycle();
      step = 1'b0; reconfigure = 1'b0;
      checks++;
      if (led !== 10'h3FF || remaining !== 4'd10) begin
         errors++;
         $display("FAIL reload+step: led=%h rem=%0d, want 3ff 10", led, remaining);
      end
   endtask

   task automatic test_expired_hold();
      dir = 1'($urandom); reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0; step = 1'b1;
      repeat (W) clk_cycle();
      for (int i = 0; i < 12; i++) begin
         step = 1'($urandom); enable = 1'($urandom);
         clk_cycle();
         checks++;
         if (led !== '0 || timeout !== 1'b1 || expired !== 1'b0 || {led, remaining, warning, timeout, expired} !== exp_vec()) begin
            errors++;
            $display("FAIL expired hold %0d: led=%h t=%b e=%b", i, led, timeout, expired);
         end
      end
      step = 1'b0; enable = 1'b0; reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0;
      checks++;
      if (timeout !== 1'b0 || led !== 10'h3FF || remaining !== 4'd10) begin
         errors++;
         $display("FAIL expired reload: t=%b led=%h rem=%0d", timeout, led, remaining);
      end
      // Back in IDLE the prescaler restarts from zero, so the first step lands on the 4th enabled cycle.
      enable = 1'b1;
      repeat (4) clk_cycle();
      enable = 1'b0;
      checks++;
      if (remaining !== 4'd9 || {led, remaining, warning, timeout, expired} !== exp_vec()) begin
         errors++;
         $display("FAIL post-reload run: rem=%0d, want 9", remaining);
      end
   endtask

   task automatic test_mid_reset();
      dir = 1'b0; reconfigure = 1'b1;
      clk_cycle();
      reconfigure = 1'b0; step = 1'b1;
      repeat (6) clk_cycle();
      step = 1'b0;
      checks++;
      if (remaining !== 4'd4 || led !== 10'h00F) begin
         errors++;
         $display("FAIL mid-run level: rem=%0d led=%h, want 4 00f", remaining, led);
      end
      rst = 1'b0; dir = 1'b1;
      clk_cycle();
      rst = 1'b1; dir = 1'b0;
      checks++;
      if (led !== 10'h3FF || remaining !== 4'd10 || {warning, timeout, expired} !== 3'b000) begin
         errors++;
         $display("FAIL mid-run reset: led=%h rem=%0d", led, remaining);
      end
      step = 1'b1;
      clk_cycle();
      step = 1'b0;
      checks++;
      if (led !== 10'h3FE) begin
         errors++;
         $display("FAIL new dir after reset: led=%h, want 3fe", led);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst         = ($urandom_range(0, 49) != 0);
         reconfigure = ($urandom_range(0, 39) == 0);
         enable      = ($urandom_range(0, 3) != 0);
         step        = ($urandom_range(0, 4) == 0);
         dir         = 1'($urandom);
         clk_cycle();
         checks++;
         if ({led, remaining, warning, timeout, expired} !== exp_vec()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h want %h", i, {led, remaining, warning, timeout, expired}, exp_vec());
         end
      end
      rst = 1'b1; reconfigure = 1'b0; enable = 1'b0; step = 1'b0;
   endtask

   initial begin
      test_reset();
      test_manual_drain();
      test_prescaler_left();
      test_pause();
      test_simultaneous();
      test_expired_hold();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
